// File: rtl/gesture_capture_ctrl.sv
// Capture sequencer in front of the finger-status classifier: synchronise and debounce
// the finger lines, classify each newly steady pose once, report the sign on valid/ready.
module gesture_capture_ctrl #(
    parameter int STABLE_CYCLES = 16,
    parameter int CLASSIFY_LAT  = 1,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [4:0] finger_raw,
    output logic [4:0] finger_latched,
    output logic       classify_start,
    input  logic [3:0] sign_value,
    output logic [3:0] sign_out,
    output logic       sign_valid,
    input  logic       sign_ready,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, SETTLE, CLASSIFY, REPORT} state_t;

    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [3:0]       WAIT_LAST  = 4'(CLASSIFY_LAT - 1);

    state_t           state;
    logic [4:0]       sync_meta;
    logic [4:0]       sync_pose;
    logic [4:0]       prev_pose;
    logic [4:0]       last_pose;
    logic             last_valid;
    logic [CNT_W-1:0] stab_cnt;
    logic [3:0]       wait_cnt;
    logic             pose_stable;
    logic             pose_new;

    // A pose that changed this very cycle is never stable, even with a saturated count.
    assign pose_stable = (stab_cnt == STABLE_MAX) && (sync_pose == prev_pose);
    assign pose_new    = !(last_valid && (sync_pose == last_pose));

    // NOTE: every register here is assigned with <= so all of them update from the same
    // pre-edge values; a blocking '=' would let later statements see already-updated state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            sync_meta      <= '0;
            sync_pose      <= '0;
            prev_pose      <= '0;
            last_pose      <= '0;
            last_valid     <= 1'b0;
            stab_cnt       <= '0;
            wait_cnt       <= '0;
            finger_latched <= '0;
            classify_start <= 1'b0;
            sign_out       <= '0;
            sign_valid     <= 1'b0;
            busy           <= 1'b0;
        end else begin
            sync_meta <= finger_raw;
            sync_pose <= sync_meta;
            prev_pose <= sync_pose;

            if (sync_pose != prev_pose)
                stab_cnt <= '0;
            else if (stab_cnt != STABLE_MAX)
                stab_cnt <= stab_cnt + 1'b1;

            // Entering SETTLE restarts the stability window; that clear wins over the count above.
            case (state)
                IDLE: begin
                    if (enable) begin
                        state    <= SETTLE;
                        busy     <= 1'b1;
                        stab_cnt <= '0;
                    end
                end

                SETTLE: begin
                    if (!enable) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        last_valid <= 1'b0;
                    end else if (pose_stable && pose_new) begin
                        finger_latched <= sync_pose;
                        classify_start <= 1'b1;
                        wait_cnt       <= '0;
                        state          <= CLASSIFY;
                    end
                end

                CLASSIFY: begin
                    // The start cycle itself is not counted toward the classifier latency.
                    if (classify_start) begin
                        classify_start <= 1'b0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        sign_out   <= sign_value;
                        sign_valid <= 1'b1;
                        state      <= REPORT;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end

                REPORT: begin
                    if (sign_valid && sign_ready) begin
                        sign_valid <= 1'b0;
                        last_pose  <= finger_latched;
                        if (enable) begin
                            state      <= SETTLE;
                            stab_cnt   <= '0;
                            last_valid <= 1'b1;
                        end else begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            last_valid <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/gesture_capture_ctrl.md
Name: gesture_capture_ctrl

Overview:
- Sequencer in front of the finger-status classifier.
- Synchronises and debounces the five raw finger-status lines, then waits for the hand pose to hold steady.
- Latches the steady pose into the classifier, starts it, and waits the classifier latency.
- Captures the 4-bit sign value and hands it downstream on a valid/ready handshake. A pose that has already been reported is suppressed until the pose changes.

Parameters:
- STABLE_CYCLES, 16: consecutive synchronised cycles a pose must hold before classification; legal range 1..255.
- CLASSIFY_LAT, 1: cycles from classify_start to a valid sign_value; legal range 1..15.
- CNT_W, 8: width of the stability counter; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk, in, 1: rising-edge clock.
- rst, in, 1: reset, synchronous, active-high.
- enable, in, 1: capture enable.
- finger_raw, in, 5: raw finger status. Bit 4 = thumb, 3 = index, 2 = middle, 1 = ring, 0 = pinky.
- finger_latched, out, 5: pose presented to the classifier. Constant outside a load.
- classify_start, out, 1: one-cycle start pulse to the classifier.
- sign_value, in, 4: classifier result.
- sign_out, out, 4: reported sign.
- sign_valid, out, 1: sign_out is valid.
- sign_ready, in, 1: downstream accepts sign_out.
- busy, out, 1: high whenever the state is not IDLE.

Behaviour:
- Reset:
  - All outputs are 0 and the state is IDLE.
  - Synchronisers, stability counter, wait counter, last_pose and last_valid are cleared.
  - rst overrides everything in every state, including mid-CLASSIFY and mid-REPORT. The pending sign is discarded and no handshake completes.
- Input path:
  - finger_raw passes through a 2-flop synchroniser to give sync_pose.
  - stab_cnt is reset to 0 in any cycle where sync_pose differs from its previous-cycle value.
  - Otherwise stab_cnt increments and saturates at STABLE_CYCLES.
  - The pose is stable when stab_cnt == STABLE_CYCLES.
- States: IDLE, SETTLE, CLASSIFY, REPORT. All outputs are registered.
- IDLE:
  - busy=0.
  - When enable=1, move to SETTLE with stab_cnt cleared.
- SETTLE:
  - If enable=0, move to IDLE next cycle.
  - When the pose is stable and not (last_valid and sync_pose == last_pose):
    - finger_latched <= sync_pose;
    - classify_start = 1 for exactly one cycle;
    - wait_cnt <= 0;
    - move to CLASSIFY.
  - A stable pose equal to last_pose keeps the block in SETTLE and issues no pulse.
  - Timing: for a pose change at edge N that then holds, classify_start is high in the cycle after edge N+STABLE_CYCLES+3.
- CLASSIFY:
  - wait_cnt counts cycles after the classify_start cycle.
  - When wait_cnt == CLASSIFY_LAT-1, sample sign_value into sign_out, set sign_valid=1 the next cycle, and move to REPORT.
  - Input bouncing and enable=0 are ignored; the transaction always completes.
- REPORT:
  - sign_out and sign_valid hold steady until sign_valid and sign_ready are both high at a clock edge.
  - On that edge: sign_valid <= 0, last_pose <= finger_latched, last_valid <= 1.
  - Then go to SETTLE with stab_cnt cleared if enable=1, otherwise to IDLE.
  - sign_ready high while sign_valid=0 has no effect.
  - The input path keeps sampling, but no new classification starts until REPORT exits.
- Entering IDLE from any state clears last_valid, so re-enabling reports the current pose again.
- Only one transaction is in flight at a time. The block adds no buffering beyond the sign_out register.

Test Plan:
(All scenarios use STABLE_CYCLES=4, CLASSIFY_LAT=1, and a model classifier with sign_value = popcount(finger_latched) registered.)
- Basic capture:
  - Stimulus: enable=1, sign_ready=1, finger_raw changes 00000->10110 at edge N.
  - Response: classify_start high in exactly one cycle, after edge N+7; finger_latched=10110; sign_out=3 with sign_valid for one cycle; busy stays 1.
- Debounce:
  - Stimulus: finger_raw toggles 01000/01001 every 2 cycles for 20 cycles, then holds 01001.
  - Response: no classify_start during the toggling; one report with sign_out=2 after the hold meets timing.
- Backpressure:
  - Stimulus: sign_ready=0 for 10 cycles after sign_valid rises; finger_raw changes to 11111 during that time.
  - Response: sign_valid and sign_out hold constant and no new classify_start occurs. After sign_ready=1 the handshake completes, then 11111 is classified and sign_out=5.
- Duplicate suppression and enable drop:
  - Stimulus: pose 00011 is reported, then held for 50 cycles.
  - Response: no second report.
  - Stimulus: enable=0 for 3 cycles, then enable=1.
  - Response: state passes through IDLE (busy=0); 00011 is reported again with sign_out=2.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle while in REPORT with sign_valid=1, sign_ready=0.
  - Response: next cycle sign_valid=0, sign_out=0, finger_latched=0, busy=0. A pose equal to the old last_pose is reported again after re-enable.
- Enable drop during CLASSIFY:
  - Stimulus: enable falls in the classify_start cycle.
  - Response: the result is still reported; after the handshake the state goes to IDLE and busy=0.
